regfile_wb_arbiter: RTL and testbench

- Shares the single register-file write port (RegWEn / WriteReg / RegWriteData) among NREQ write-back requesters, e.g. ALU, load unit and CSR unit.
- Uses round-robin arbitration with a valid/ready handshake per requester.
- Grants at most one write per cycle and presents it to the register file from a registered output stage.
- Sits between the execute/memory stages and the register file.

---
 rtl/regfile_wb_arbiter.sv | 135 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the single register-file write port among NREQ write-back
//   requesters (e.g. ALU, load unit, CSR unit) using round-robin
//   arbitration. At most one write is granted per cycle, and the granted
//   write is presented to the register file from a registered output stage.
//
// Parameters
//   NREQ  number of write-back requesters (2..8)
//   RR_W  width of the round-robin pointer; 2**RR_W >= NREQ
//
// Ports
//   clk           clock, rising edge
//   rst           asynchronous reset, active low
//   req_valid     [NREQ]     requester i has a write pending
//   req_rd        [5*NREQ]   destination register of requester i, [5i+4:5i]
//   req_data      [32*NREQ]  write data of requester i, [32i+31:32i]
//   req_ready     [NREQ]     one-hot grant (transfer on valid & ready)
//   wb_stall      suppresses all grants this cycle
//   RegWEn        registered write enable to the register file
//   WriteReg      registered write address
//   RegWriteData  registered write data
//   wb_busy       any request pending or a write in flight
//
// Optional feature (macro WB_FWD_EN)
//   fwd_rs1/fwd_rs2 in, fwd_hit1/fwd_hit2 and fwd_data1/fwd_data2 out:
//   combinational bypass of the write currently in flight.
module regfile_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int RR_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [5*NREQ-1:0]  req_rd,
  input  logic [32*NREQ-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  input  logic               wb_stall,
  output logic               RegWEn,
  output logic [4:0]         WriteReg,
  output logic [31:0]        RegWriteData,
  output logic               wb_busy
`ifdef WB_FWD_EN
  ,
  input  logic [4:0]         fwd_rs1,
  input  logic [4:0]         fwd_rs2,
  output logic               fwd_hit1,
  output logic               fwd_hit2,
  output logic [31:0]        fwd_data1,
  output logic [31:0]        fwd_data2
`endif
);

  logic [RR_W-1:0] rr_ptr;

  logic [NREQ-1:0] cand_p0;
  logic [NREQ-1:0] gnt_p0;
  logic            gnt_vld_p0;
  logic [RR_W-1:0] gnt_idx_p0;
  logic [4:0]      sel_rd_p0;
  logic [31:0]     sel_data_p0;

  // Stage p0: combinational round-robin selection.
  // The search order rr_ptr, rr_ptr+1, ..., wrapping at NREQ is realised as
  // two ascending passes: indices at or above rr_ptr first, then the ones
  // below it. This keeps every vector index a loop constant.
  always_comb begin
    cand_p0     = req_valid & ~{NREQ{wb_stall}};
    gnt_p0      = '0;
    gnt_vld_p0  = 1'b0;
    gnt_idx_p0  = '0;
    sel_rd_p0   = '0;
    sel_data_p0 = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!gnt_vld_p0 && cand_p0[i] && (RR_W'(i) >= rr_ptr)) begin
        gnt_vld_p0  = 1'b1;
        gnt_p0[i]   = 1'b1;
        gnt_idx_p0  = RR_W'(i);
        sel_rd_p0   = req_rd[5*i +: 5];
        sel_data_p0 = req_data[32*i +: 32];
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!gnt_vld_p0 && cand_p0[i] && (RR_W'(i) < rr_ptr)) begin
        gnt_vld_p0  = 1'b1;
        gnt_p0[i]   = 1'b1;
        gnt_idx_p0  = RR_W'(i);
        sel_rd_p0   = req_rd[5*i +: 5];
        sel_data_p0 = req_data[32*i +: 32];
      end
    end
    // No handshake may complete while the block is held in reset.
    if (!rst) begin
      gnt_p0     = '0;
      gnt_vld_p0 = 1'b0;
    end
  end

  assign req_ready = gnt_p0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= '0;
    end else if (gnt_vld_p0) begin
      rr_ptr <= (gnt_idx_p0 == RR_W'(NREQ-1)) ? '0 : gnt_idx_p0 + RR_W'(1);
    end
  end

  // Stage p1: registered write port. A granted rd=0 request still
  // updates address/data but never raises the enable, so x0 is never written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWEn       <= 1'b0;
      WriteReg     <= '0;
      RegWriteData <= '0;
    end else begin
      RegWEn <= gnt_vld_p0 && (sel_rd_p0 != 5'd0);
      if (gnt_vld_p0) begin
        WriteReg     <= sel_rd_p0;
        RegWriteData <= sel_data_p0;
      end
    end
  end

  assign wb_busy = (|req_valid) | RegWEn;

`ifdef WB_FWD_EN
  // The register file returns the old value on read-during-write; these
  // taps expose the write currently on the port to same-cycle readers.
  assign fwd_hit1  = RegWEn & (WriteReg == fwd_rs1) & (fwd_rs1 != 5'd0);
  assign fwd_hit2  = RegWEn & (WriteReg == fwd_rs2) & (fwd_rs2 != 5'd0);
  assign fwd_data1 = fwd_hit1 ? RegWriteData : 32'd0;
  assign fwd_data2 = fwd_hit2 ? RegWriteData : 32'd0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  localparam int NREQ = 3;
  localparam int RR_W = 2;

  logic               clk;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [5*NREQ-1:0]  req_rd;
  logic [32*NREQ-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               wb_stall;
  logic               RegWEn;
  logic [4:0]         WriteReg;
  logic [31:0]        RegWriteData;
  logic               wb_busy;
`ifdef WB_FWD_EN
  logic [4:0]         fwd_rs1, fwd_rs2;
  logic               fwd_hit1, fwd_hit2;
  logic [31:0]        fwd_data1, fwd_data2;
`endif

  regfile_wb_arbiter #(.NREQ(NREQ), .RR_W(RR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_rd       (req_rd),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .wb_stall     (wb_stall),
    .RegWEn       (RegWEn),
    .WriteReg     (WriteReg),
    .RegWriteData (RegWriteData),
    .wb_busy      (wb_busy)
`ifdef WB_FWD_EN
    ,
    .fwd_rs1      (fwd_rs1),
    .fwd_rs2      (fwd_rs2),
    .fwd_hit1     (fwd_hit1),
    .fwd_hit2     (fwd_hit2),
    .fwd_data1    (fwd_data1),
    .fwd_data2    (fwd_data2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  valid;
    logic        stall;
    logic [4:0]  rd0, rd1, rd2;
    logic [31:0] d0, d1, d2;
    logic [2:0]  ready;
    logic        wen;
    logic [4:0]  wr;
    logic [31:0] wd;
  } vec_t;

  function automatic vec_t mk(input logic [2:0] v, input logic s,
                              input logic [4:0] r0, input logic [31:0] a0,
                              input logic [4:0] r1, input logic [31:0] a1,
                              input logic [4:0] r2, input logic [31:0] a2,
                              input logic [2:0] rdy, input logic we,
                              input logic [4:0] wr, input logic [31:0] wd);
    vec_t t;
    t.valid = v; t.stall = s;
    t.rd0 = r0; t.d0 = a0; t.rd1 = r1; t.d1 = a1; t.rd2 = r2; t.d2 = a2;
    t.ready = rdy; t.wen = we; t.wr = wr; t.wd = wd;
    return t;
  endfunction

  localparam int NV = 20;
  vec_t tbl [NV];

  // Reference model state
  int          m_ptr;
  logic        m_wen;
  logic [4:0]  m_wr;
  logic [31:0] m_wd;
  logic        pend [NREQ];
  logic [4:0]  prd  [NREQ];
  logic [31:0] pdat [NREQ];
  int          waitc[NREQ];

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst = 1'b0;
    wb_stall = 1'b0;
    req_valid = 3'b111;
    req_rd = {5'd3, 5'd2, 5'd1};
    req_data = {32'h33, 32'h22, 32'h11};
`ifdef WB_FWD_EN
    fwd_rs1 = 5'd0;
    fwd_rs2 = 5'd0;
`endif

    // Test vectors, applied one per cycle starting right after reset.
    // Expected outputs: comb grant this cycle, registered port from last cycle.
    tbl[0]  = mk(3'b111, 0, 1, 32'h11, 2, 32'h22, 3, 32'h33, 3'b001, 0, 0, 32'h0);
    tbl[1]  = mk(3'b010, 0, 1, 32'h11, 5, 32'hDEADBEEF, 3, 32'h33, 3'b010, 1, 1, 32'h11);
    tbl[2]  = mk(3'b000, 0, 1, 32'h11, 2, 32'h22, 3, 32'h33, 3'b000, 1, 5, 32'hDEADBEEF);
    tbl[3]  = mk(3'b000, 0, 1, 32'h11, 2, 32'h22, 3, 32'h33, 3'b000, 0, 5, 32'hDEADBEEF);
    tbl[4]  = mk(3'b111, 0, 1, 32'h11, 2, 32'h22, 3, 32'h33, 3'b100, 0, 5, 32'hDEADBEEF);
    tbl[5]  = mk(3'b111, 0, 1, 32'h11, 2, 32'h22, 3, 32'h33, 3'b001, 1, 3, 32'h33);
    tbl[6]  = mk(3'b111, 0, 1, 32'h11, 2, 32'h22, 3, 32'h33, 3'b010, 1, 1, 32'h11);
    tbl[7]  = mk(3'b111, 0, 1, 32'h11, 2, 32'h22, 3, 32'h33, 3'b100, 1, 2, 32'h22);
    tbl[8]  = mk(3'b000, 0, 1, 32'h11, 2, 32'h22, 3, 32'h33, 3'b000, 1, 3, 32'h33);
    tbl[9]  = mk(3'b100, 0, 1, 32'h11, 2, 32'h22, 0, 32'h1234, 3'b100, 0, 3, 32'h33);
    tbl[10] = mk(3'b011, 0, 1, 32'h11, 2, 32'h22, 3, 32'h33, 3'b001, 0, 0, 32'h1234);
    tbl[11] = mk(3'b000, 0, 1, 32'h11, 2, 32'h22, 3, 32'h33, 3'b000, 1, 1, 32'h11);
    tbl[12] = mk(3'b001, 1, 4, 32'h44, 2, 32'h22, 3, 32'h33, 3'b000, 0, 1, 32'h11);
    tbl[13] = mk(3'b001, 1, 4, 32'h44, 2, 32'h22, 3, 32'h33, 3'b000, 0, 1, 32'h11);
    tbl[14] = mk(3'b001, 1, 4, 32'h44, 2, 32'h22, 3, 32'h33, 3'b000, 0, 1, 32'h11);
    tbl[15] = mk(3'b001, 0, 4, 32'h44, 2, 32'h22, 3, 32'h33, 3'b001, 0, 1, 32'h11);
    tbl[16] = mk(3'b000, 0, 4, 32'h44, 2, 32'h22, 3, 32'h33, 3'b000, 1, 4, 32'h44);
    tbl[17] = mk(3'b010, 0, 4, 32'h44, 6, 32'h66, 3, 32'h33, 3'b010, 0, 4, 32'h44);
    tbl[18] = mk(3'b010, 1, 4, 32'h44, 6, 32'h66, 3, 32'h33, 3'b000, 1, 6, 32'h66);
    tbl[19] = mk(3'b000, 0, 4, 32'h44, 6, 32'h66, 3, 32'h33, 3'b000, 0, 6, 32'h66);

    // Reset held with all requesters valid
    repeat (3) @(negedge clk);
    #1;
    chk("reset_ready", 32'(req_ready), 32'h0);
    chk("reset_wen", 32'(RegWEn), 32'h0);
    chk("reset_wr", 32'(WriteReg), 32'h0);
    chk("reset_wd", RegWriteData, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    for (int v = 0; v < NV; v++) begin
      req_valid = tbl[v].valid;
      wb_stall  = tbl[v].stall;
      req_rd    = {tbl[v].rd2, tbl[v].rd1, tbl[v].rd0};
      req_data  = {tbl[v].d2, tbl[v].d1, tbl[v].d0};
      #1;
      chk($sformatf("vec%0d_ready", v), 32'(req_ready), 32'(tbl[v].ready));
      chk($sformatf("vec%0d_wen", v), 32'(RegWEn), 32'(tbl[v].wen));
      chk($sformatf("vec%0d_wr", v), 32'(WriteReg), 32'(tbl[v].wr));
      chk($sformatf("vec%0d_wd", v), RegWriteData, tbl[v].wd);
      chk($sformatf("vec%0d_busy", v), 32'(wb_busy), 32'((|tbl[v].valid) | tbl[v].wen));
      @(posedge clk);
      @(negedge clk);
    end

`ifdef WB_FWD_EN
    // Pointer is at 2 here; req0 is the only candidate.
    req_valid = 3'b001;
    wb_stall  = 1'b0;
    req_rd    = {5'd3, 5'd2, 5'd7};
    req_data  = {32'h33, 32'h22, 32'hA5A5A5A5};
    #1;
    chk("fwd_grant", 32'(req_ready), 32'h1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 3'b000;
    fwd_rs1 = 5'd7;
    fwd_rs2 = 5'd0;
    #1;
    chk("fwd_hit1", 32'(fwd_hit1), 32'h1);
    chk("fwd_data1", fwd_data1, 32'hA5A5A5A5);
    chk("fwd_hit2", 32'(fwd_hit2), 32'h0);
    chk("fwd_data2", fwd_data2, 32'h0);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("fwd_hit1_idle", 32'(fwd_hit1), 32'h0);
    chk("fwd_data1_idle", fwd_data1, 32'h0);
`endif

    // Reset in the middle of a write that is on the port
    req_valid = 3'b010;
    wb_stall  = 1'b0;
    req_rd    = {5'd3, 5'd9, 5'd1};
    req_data  = {32'h33, 32'h99, 32'h11};
    @(posedge clk);
    #1;
    req_valid = 3'b000;
    #1;
    chk("midrst_pre_wen", 32'(RegWEn), 32'h1);
    chk("midrst_pre_wr", 32'(WriteReg), 32'h9);
    rst = 1'b0;
    #1;
    chk("midrst_wen", 32'(RegWEn), 32'h0);
    chk("midrst_wr", 32'(WriteReg), 32'h0);
    chk("midrst_wd", RegWriteData, 32'h0);
    req_valid = 3'b111;
    #1;
    chk("midrst_ready", 32'(req_ready), 32'h0);
    req_valid = 3'b000;
    @(negedge clk);
    rst = 1'b1;

    // Randomized traffic against the reference model (from reset state)
    m_ptr = 0;
    m_wen = 1'b0;
    m_wr  = '0;
    m_wd  = '0;
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 1'b0;
      prd[i] = '0;
      pdat[i] = '0;
      waitc[i] = 0;
    end
    for (int c = 0; c < 400; c++) begin
      int g;
      logic [2:0] exp_rdy;
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && ($urandom_range(0, 2) == 0)) begin
          pend[i] = 1'b1;
          prd[i]  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
          pdat[i] = $urandom;
          waitc[i] = 0;
        end
      end
      wb_stall = ($urandom_range(0, 4) == 0);
      req_valid = {pend[2], pend[1], pend[0]};
      req_rd    = {prd[2], prd[1], prd[0]};
      req_data  = {pdat[2], pdat[1], pdat[0]};
      #1;
      g = -1;
      if (!wb_stall) begin
        for (int k = 0; k < NREQ; k++) begin
          int i;
          i = (m_ptr + k) % NREQ;
          if (g < 0 && pend[i]) g = i;
        end
      end
      exp_rdy = (g >= 0) ? 3'(1 << g) : 3'b000;
      chk($sformatf("rnd%0d_ready", c), 32'(req_ready), 32'(exp_rdy));
      chk($sformatf("rnd%0d_wen", c), 32'(RegWEn), 32'(m_wen));
      chk($sformatf("rnd%0d_wr", c), 32'(WriteReg), 32'(m_wr));
      chk($sformatf("rnd%0d_wd", c), RegWriteData, m_wd);
      chk($sformatf("rnd%0d_busy", c), 32'(wb_busy),
          32'(pend[0] | pend[1] | pend[2] | m_wen));
      if (!wb_stall) begin
        for (int i = 0; i < NREQ; i++) if (pend[i]) waitc[i]++;
      end
      if (g >= 0) begin
        n_chk++;
        if (waitc[g] > NREQ) begin
          n_fail++;
          $display("FAIL rnd%0d_fair: req%0d waited %0d cycles, bound %0d", c, g, waitc[g], NREQ);
        end
        m_wen = (prd[g] != 5'd0);
        m_wr  = prd[g];
        m_wd  = pdat[g];
        m_ptr = (g == NREQ - 1) ? 0 : g + 1;
        pend[g] = 1'b0;
      end else begin
        m_wen = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
